// File: rtl/axi4_stream_pkg.sv
// Shared definitions for AXI4-Stream building blocks.
// beat_width gives the packed width of one stored beat including all sideband fields.
package axi4_stream_pkg;

  function automatic int unsigned beat_width(
    input int unsigned data_w,
    input int unsigned id_w,
    input int unsigned dest_w,
    input int unsigned user_w
  );
    // tdata + tstrb + tkeep + tlast + tid + tdest + tuser
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream link with master (source) and slave (sink) views.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned USER_WIDTH = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic [STRB_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4_stream_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axi4_stream_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata_c
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];
endmodule

// File: rtl/axi4_stream_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with optional store-and-forward packet mode.
// Handshake and status outputs are registered from next-state occupancy.
module axi4_stream_fifo
  import axi4_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned DEST_WIDTH   = 4,
  parameter int unsigned USER_WIDTH   = 4,
  parameter int unsigned WORDS_AMOUNT = 16,
  parameter int unsigned PACKET_MODE  = 0
) (
  input  logic                          aclk,
  input  logic                          areset,
  axi4_stream_if.slave                  pkt_i,
  axi4_stream_if.master                 pkt_o,
  output logic [$clog2(WORDS_AMOUNT):0] used_words,
  output logic                          full,
  output logic                          empty
);
  localparam int unsigned AW = $clog2(WORDS_AMOUNT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = beat_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_used;
  logic [CW-1:0] r_pkt_cnt;
  logic          r_tready;
  logic          r_tvalid;
  logic          r_full;
  logic          r_empty;

  logic          w_wr;
  logic          w_rd;
  logic [CW-1:0] w_used_next;
  logic [CW-1:0] w_pkt_cnt_next;
  logic          w_full_next;
  logic          w_tvalid_next;
  logic [BW-1:0] w_wr_beat;
  logic [BW-1:0] w_rd_beat;

  assign w_wr = pkt_i.tvalid && r_tready;
  assign w_rd = r_tvalid && pkt_o.tready;

  assign w_wr_beat = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                      pkt_i.tid, pkt_i.tdest, pkt_i.tuser};

  axi4_stream_fifo_ram #(
    .WIDTH (BW),
    .DEPTH (WORDS_AMOUNT)
  ) u_ram (
    .clk       (aclk),
    .i_we      (w_wr),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (w_wr_beat),
    .i_raddr   (r_rd_ptr),
    .o_rdata_c (w_rd_beat)
  );

  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast,
          pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = w_rd_beat;

  // Next occupancy, packet count and derived handshake state.
  always_comb begin
    w_used_next    = r_used;
    w_pkt_cnt_next = r_pkt_cnt;
    if (w_wr && !w_rd)      w_used_next = r_used + CW'(1);
    else if (!w_wr && w_rd) w_used_next = r_used - CW'(1);
    if ((w_wr && pkt_i.tlast) && !(w_rd && pkt_o.tlast))      w_pkt_cnt_next = r_pkt_cnt + CW'(1);
    else if (!(w_wr && pkt_i.tlast) && (w_rd && pkt_o.tlast)) w_pkt_cnt_next = r_pkt_cnt - CW'(1);
    w_full_next   = (w_used_next == CW'(WORDS_AMOUNT));
    // The full term releases a packet longer than the depth instead of deadlocking.
    w_tvalid_next = (w_used_next != CW'(0)) &&
                    ((PACKET_MODE == 0) || (w_pkt_cnt_next != CW'(0)) || w_full_next);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_used    <= '0;
      r_pkt_cnt <= '0;
      r_tready  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_used    <= w_used_next;
      r_pkt_cnt <= w_pkt_cnt_next;
      r_tready  <= (w_used_next < CW'(WORDS_AMOUNT));
      r_tvalid  <= w_tvalid_next;
      r_full    <= w_full_next;
      r_empty   <= (w_used_next == CW'(0));
    end
  end

  assign pkt_i.tready = r_tready;
  assign pkt_o.tvalid = r_tvalid;
  assign used_words   = r_used;
  assign full         = r_full;
  assign empty        = r_empty;
endmodule
